// File: rtl/control_filtro.sv
// Sequencing controller for a second-order filter MAC datapath: shift the sample
// history, clear the accumulator, step through NTERMS coefficients, load the output.
// Latency: start seen at edge k -> shift in cycle k+1, done in cycle k+3+NTERMS.
// Backpressure: none. A start seen while busy is dropped and raises the sticky ovr flag.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   en, start, clr_ovr      enable, new-sample strobe, overrun clear
//   shift, acc_clr, acc_en  history shift, accumulator clear/enable
//   sel                     operand index during MAC terms (0 otherwise)
//   y_load, done, busy      output load, completion pulse, in-progress flag
//   ovr, sample_cnt         sticky overrun, completed-sample counter (wraps)
module control_filtro #(
    parameter int NTERMS = 5,
    parameter int SEL_W  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             start,
    input  logic             clr_ovr,
    output logic             shift,
    output logic             acc_clr,
    output logic             acc_en,
    output logic [SEL_W-1:0] sel,
    output logic             y_load,
    output logic             done,
    output logic             busy,
    output logic             ovr,
    output logic [15:0]      sample_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        MAC   = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [SEL_W-1:0] LAST_TERM = SEL_W'(NTERMS - 1);

    state_t           state;
    logic [SEL_W-1:0] term;

    // Every output is a register written alongside the state transition, so each
    // output already reflects the state being entered (Moore timing, no input paths).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            term       <= '0;
            shift      <= 1'b0;
            acc_clr    <= 1'b0;
            acc_en     <= 1'b0;
            sel        <= '0;
            y_load     <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            ovr        <= 1'b0;
            sample_cnt <= 16'd0;
        end else begin
            // Pulse outputs default low; only the entering transition raises them.
            shift   <= 1'b0;
            acc_clr <= 1'b0;
            y_load  <= 1'b0;
            done    <= 1'b0;

            // Overrun set has priority over clear when both happen on one edge.
            if (start && (state != IDLE)) begin
                ovr <= 1'b1;
            end else if (clr_ovr) begin
                ovr <= 1'b0;
            end

            case (state)
                IDLE: begin
                    acc_en <= 1'b0;
                    sel    <= '0;
                    term   <= '0;
                    if (en && start) begin
                        state   <= SHIFT;
                        shift   <= 1'b1;
                        acc_clr <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    state  <= MAC;
                    term   <= '0;
                    acc_en <= 1'b1;
                    sel    <= '0;
                end
                MAC: begin
                    if (term == LAST_TERM) begin
                        state  <= LOAD;
                        term   <= '0;
                        acc_en <= 1'b0;
                        sel    <= '0;
                        y_load <= 1'b1;
                    end else begin
                        term <= term + 1'b1;
                        sel  <= term + 1'b1;
                    end
                end
                LOAD: begin
                    state      <= DONE;
                    done       <= 1'b1;
                    sample_cnt <= sample_cnt + 16'd1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    // Unused encodings recover straight to a quiet IDLE.
                    state  <= IDLE;
                    term   <= '0;
                    acc_en <= 1'b0;
                    sel    <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_filtro.sv
module tb_control_filtro;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        start;
    logic        clr_ovr;
    logic        shift;
    logic        acc_clr;
    logic        acc_en;
    logic [2:0]  sel;
    logic        y_load;
    logic        done;
    logic        busy;
    logic        ovr;
    logic [15:0] sample_cnt;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    control_filtro #(.NTERMS(5), .SEL_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .start      (start),
        .clr_ovr    (clr_ovr),
        .shift      (shift),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .sel        (sel),
        .y_load     (y_load),
        .done       (done),
        .busy       (busy),
        .ovr        (ovr),
        .sample_cnt (sample_cnt)
    );

    // Observed control vector {shift, acc_clr, acc_en, sel[2:0], y_load, done, busy}.
    function automatic logic [8:0] obs_vec();
        return {shift, acc_clr, acc_en, sel, y_load, done, busy};
    endfunction

    // Hand table of the expected control vector in cycle n after the start edge (NTERMS=5).
    function automatic logic [8:0] exp_vec(input int n);
        case (n)
            1:       return 9'b1_1_0_000_0_0_1;
            2:       return 9'b0_0_1_000_0_0_1;
            3:       return 9'b0_0_1_001_0_0_1;
            4:       return 9'b0_0_1_010_0_0_1;
            5:       return 9'b0_0_1_011_0_0_1;
            6:       return 9'b0_0_1_100_0_0_1;
            7:       return 9'b0_0_0_000_1_0_1;
            8:       return 9'b0_0_0_000_0_1_1;
            default: return 9'b0_0_0_000_0_0_0;
        endcase
    endfunction

    task automatic test_reset;
        reset_n = 1'b0;
        en      = 1'b0;
        start   = 1'b0;
        clr_ovr = 1'b0;
        #3;
        n_total++;
        if ({obs_vec(), ovr, sample_cnt} !== 26'd0) begin
            $display("FAIL reset_outputs: got %h want 0", {obs_vec(), ovr, sample_cnt});
        end else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        en      = 1'b1;
        @(negedge clk);
        n_total++;
        if ({obs_vec(), ovr, sample_cnt} !== 26'd0) begin
            $display("FAIL reset_release_idle: got %h want 0", {obs_vec(), ovr, sample_cnt});
        end else n_pass++;
    endtask

    task automatic test_single;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            start = 1'b0;
            n_total++;
            if (obs_vec() !== exp_vec(n)) begin
                $display("FAIL single_cycle%0d: got %b want %b", n, obs_vec(), exp_vec(n));
            end else n_pass++;
        end
        exp_cnt = exp_cnt + 16'd1;
        n_total++;
        if (sample_cnt !== exp_cnt) begin
            $display("FAIL single_count: got %0d want %0d", sample_cnt, exp_cnt);
        end else n_pass++;
        n_total++;
        if (ovr !== 1'b0) begin
            $display("FAIL single_ovr: got %b want 0", ovr);
        end else n_pass++;
    endtask

    task automatic test_overrun;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec() !== exp_vec(n)) begin
                $display("FAIL overrun_cycle%0d: got %b want %b", n, obs_vec(), exp_vec(n));
            end else n_pass++;
            // Extra start sampled at the edge ending MAC term 2 (cycle 4).
            start = (n == 4);
        end
        exp_cnt = exp_cnt + 16'd1;
        n_total++;
        if ({ovr, sample_cnt} !== {1'b1, exp_cnt}) begin
            $display("FAIL overrun_flag_count: got %b/%0d want 1/%0d", ovr, sample_cnt, exp_cnt);
        end else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, sample_cnt} !== {1'b0, exp_cnt}) begin
            $display("FAIL overrun_discarded: got busy=%b cnt=%0d want 0/%0d", busy, sample_cnt, exp_cnt);
        end else n_pass++;
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        n_total++;
        if (ovr !== 1'b0) begin
            $display("FAIL overrun_clear: got %b want 0", ovr);
        end else n_pass++;

        // Clear and overrun on the same edge: the set must win.
        start = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 5) begin
                n_total++;
                if (ovr !== 1'b1) begin
                    $display("FAIL overrun_set_wins: got %b want 1", ovr);
                end else n_pass++;
            end
            start   = (n == 4);
            clr_ovr = (n == 4);
        end
        exp_cnt = exp_cnt + 16'd1;
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
    endtask

    task automatic test_enable;
        en = 1'b0;
        for (int n = 0; n < 6; n++) begin
            start = n[0];
            @(negedge clk);
            n_total++;
            if ({shift, busy, ovr} !== 3'b000) begin
                $display("FAIL en_low_ignore%0d: got %b want 000", n, {shift, busy, ovr});
            end else n_pass++;
        end
        start = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 3) en = 1'b0;
            n_total++;
            if (obs_vec() !== exp_vec(n)) begin
                $display("FAIL en_drop_cycle%0d: got %b want %b", n, obs_vec(), exp_vec(n));
            end else n_pass++;
        end
        exp_cnt = exp_cnt + 16'd1;
        start = 1'b1;
        repeat (10) @(negedge clk);
        n_total++;
        if ({busy, ovr, sample_cnt} !== {2'b00, exp_cnt}) begin
            $display("FAIL en_drop_no_more: got %b/%b/%0d want 0/0/%0d", busy, ovr, sample_cnt, exp_cnt);
        end else n_pass++;
        start = 1'b0;
        en    = 1'b1;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            n_total++;
            if (shift !== ((n % 9) == 1 && n < 28)) begin
                $display("FAIL b2b_shift_cycle%0d: got %b want %b", n, shift, ((n % 9) == 1 && n < 28));
            end else n_pass++;
            if (n == 27) start = 1'b0;
        end
        exp_cnt = exp_cnt + 16'd3;
        n_total++;
        if ({busy, ovr, sample_cnt} !== {2'b01, exp_cnt}) begin
            $display("FAIL b2b_final: got %b/%b/%0d want 0/1/%0d", busy, ovr, sample_cnt, exp_cnt);
        end else n_pass++;
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        // Cycle 5 is MAC term 3; drop reset between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        exp_cnt = 16'd0;
        n_total++;
        if ({obs_vec(), ovr, sample_cnt} !== 26'd0) begin
            $display("FAIL reset_mid_async: got %h want 0", {obs_vec(), ovr, sample_cnt});
        end else n_pass++;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            n_total++;
            if ({done, y_load, sample_cnt} !== 18'd0) begin
                $display("FAIL reset_mid_hold%0d: got %h want 0", n, {done, y_load, sample_cnt});
            end else n_pass++;
        end
        reset_n = 1'b1;
        start   = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            start = 1'b0;
            n_total++;
            if (obs_vec() !== exp_vec(n)) begin
                $display("FAIL reset_restart_cycle%0d: got %b want %b", n, obs_vec(), exp_vec(n));
            end else n_pass++;
        end
        exp_cnt = exp_cnt + 16'd1;
        n_total++;
        if (sample_cnt !== exp_cnt) begin
            $display("FAIL reset_restart_count: got %0d want %0d", sample_cnt, exp_cnt);
        end else n_pass++;
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.sample_cnt = 16'hFFFF;
        #1;
        release dut.sample_cnt;
        exp_cnt = 16'h0000;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 8) begin
                n_total++;
                if ({done, sample_cnt} !== {1'b1, exp_cnt}) begin
                    $display("FAIL wrap_count: got done=%b cnt=%h want 1/%h", done, sample_cnt, exp_cnt);
                end else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
